// File: rtl/ss_nbit_serial.sv
// ss_nbit_serial: bit-serial magnitude comparator, MSB first, one bit per clock.
// Handles unsigned or two's-complement operands; reports A>B (lon), A=B (bang),
// A<B (be), with a single-cycle done pulse.
module ss_nbit_serial #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         lon,
  output logic         bang,
  output logic         be
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] IMAX = IW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          sm_q;
  logic [IW-1:0] i;

  logic a_bit;
  logic b_bit;
  logic bits_differ;
  logic a_greater;

  // Decide the outcome of the bit under examination; in signed mode the sign
  // bit inverts the sense, since a set sign bit marks the smaller operand.
  always_comb begin
    a_bit       = a_q[i];
    b_bit       = b_q[i];
    bits_differ = a_bit ^ b_bit;
    if (sm_q && (i == IMAX)) begin
      a_greater = ~a_bit;
    end else begin
      a_greater = a_bit;
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sm_q  <= 1'b0;
      i     <= IMAX;
      busy  <= 1'b0;
      done  <= 1'b0;
      lon   <= 1'b0;
      bang  <= 1'b0;
      be    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && E) begin
            a_q   <= A;
            b_q   <= B;
            sm_q  <= signed_mode;
            i     <= IMAX;
            lon   <= 1'b0;
            bang  <= 1'b0;
            be    <= 1'b0;
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (!E) begin
            lon   <= 1'b0;
            bang  <= 1'b0;
            be    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
          end else if (bits_differ) begin
            lon   <= a_greater;
            be    <= ~a_greater;
            done  <= 1'b1;
            state <= DONE;
          end else if (i == '0) begin
            bang  <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i <= i - 1'b1;
          end
        end
        DONE: begin
          // Results are held; E and start have no effect here.
          done  <= 1'b0;
          busy  <= 1'b0;
          i     <= IMAX;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_nbit_serial.sv
// Directed bench for ss_nbit_serial (W=8). Outputs checked as the vector
// {busy, done, lon, bang, be} one time unit after each rising edge.
module tb_ss_nbit_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       E;
  logic       start;
  logic       signed_mode;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic       lon;
  logic       bang;
  logic       be;
  logic [4:0] outs;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  ss_nbit_serial #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .E(E), .start(start), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy), .done(done), .lon(lon), .bang(bang), .be(be)
  );

  always #5 clk = ~clk;

  assign outs = {busy, done, lon, bang, be};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    total++;
    assert (outs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b (busy,done,lon,bang,be)", tag, outs, exp);
    end
  endtask

  task automatic go(input logic [7:0] a, input logic [7:0] b, input logic sm);
    A = a; B = b; signed_mode = sm; start = 1'b1; E = 1'b1;
    step();
    start = 1'b0;
    A = ~a; B = ~b; signed_mode = ~sm;
  endtask

  initial begin
    rst_n = 1'b0; E = 1'b0; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
    step(); step();
    chk("reset", 5'b00000);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 5'b00000);

    // Unsigned 0x80 vs 0x7F: decided on the MSB, one edge after accept.
    go(8'h80, 8'h7F, 1'b0);
    chk("u80_accept", 5'b10000);
    step();
    chk("u80_done", 5'b11100);
    step();
    chk("u80_idle", 5'b00100);

    // Signed 0x80 vs 0x7F: -128 < 127. Start held through DONE is not accepted.
    go(8'h80, 8'h7F, 1'b1);
    step();
    chk("s80_done", 5'b11001);
    start = 1'b1;
    step();
    chk("s80_start_in_done_ignored", 5'b00001);
    start = 1'b0;
    step();
    chk("s80_hold", 5'b00001);

    // Unsigned 3 vs 5: first difference at bit 2 -> done at accept+6.
    go(8'h03, 8'h05, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("u35_busy_e%0d", k), 5'b10000);
    end
    step();
    chk("u35_done_e6", 5'b11001);
    step();
    chk("u35_idle", 5'b00001);

    // Equal 0x5A -> bang at accept+8; E=0 sampled in DONE has no effect.
    go(8'h5A, 8'h5A, 1'b0);
    for (int k = 1; k <= 7; k++) step();
    chk("eq_busy_e7", 5'b10000);
    step();
    chk("eq_done_e8", 5'b11010);
    E = 1'b0;
    step();
    chk("eq_e0_in_done_kept", 5'b00010);

    // Start with E=0 is not accepted; results unchanged.
    start = 1'b1; A = 8'h01; B = 8'h02;
    step();
    chk("start_e0_ignored", 5'b00010);
    start = 1'b0;
    step();
    chk("start_e0_still_idle", 5'b00010);

    // Abort: E=0 sampled at accept+3 clears everything, no done afterwards.
    go(8'h5A, 8'h5A, 1'b0);
    step(); step();
    E = 1'b0;
    step();
    chk("abort_e3", 5'b00000);
    for (int k = 0; k < 8; k++) step();
    chk("abort_no_done", 5'b00000);
    go(8'h80, 8'h7F, 1'b0);
    step();
    chk("after_abort_done", 5'b11100);
    step();

    // Start pulsed at accept+2 with other operands is ignored.
    go(8'h03, 8'h05, 1'b0);
    step();
    start = 1'b1; A = 8'h80; B = 8'h7F;
    step();
    start = 1'b0;
    chk("busy_start_ignored_e2", 5'b10000);
    step(); step(); step();
    chk("busy_start_e5", 5'b10000);
    step();
    chk("busy_start_result_e6", 5'b11001);
    step();

    // Reset at accept+4 discards the compare.
    go(8'h5A, 8'h5A, 1'b0);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    chk("reset_mid_compare", 5'b00000);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("reset_no_done", 5'b00000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
